// File: rtl/mod461_residue_accumulator.sv
// mod461_residue_accumulator
// Folds a frame of N_CHUNKS partial residues (one per accepted beat) into a
// single residue modulo MODULUS and presents it on an output valid/ready port.
// Each beat is reduced with one conditional subtract, so the accumulator always
// stays below MODULUS.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. ready never depends combinationally on valid. Once out_valid is
// raised, out_valid and out_residue stay stable until out_ready is seen.
// A synchronous flush overrides both handshakes in its cycle.
module mod461_residue_accumulator #(
  parameter int unsigned MODULUS  = 461,
  parameter int unsigned RW       = 9,
  parameter int unsigned N_CHUNKS = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_residue,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_residue,
  output logic          busy,
  output logic          err_range,
  output logic [1:0]    dbg_state
);

  localparam int unsigned CW = $clog2(N_CHUNKS + 1);
  localparam logic [RW:0] MOD_W = (RW+1)'(MODULUS);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [RW-1:0] acc;
  logic [CW-1:0] cnt;

  logic [RW:0]   in_ext;
  logic          in_over;
  logic [RW-1:0] r_norm;
  logic [RW-1:0] acc_base;
  logic [RW:0]   sum;
  logic [RW-1:0] acc_next;
  logic          last_beat;
  logic          accept;
  logic          release_out;

  // Current FSM state, made visible for observation.
  assign dbg_state = state;

  // A beat is taken only when the block is ready and no flush is pending.
  assign accept      = in_valid & in_ready & ~flush;
  assign release_out = (state == S_DONE) & out_ready & ~flush;

  // Per-beat datapath: normalise the input, add, one conditional subtract.
  always_comb begin
    in_ext    = {1'b0, in_residue};
    in_over   = (in_ext >= MOD_W);
    r_norm    = in_over ? RW'(in_ext - MOD_W) : in_residue;
    // The first beat of a frame starts from zero regardless of acc.
    acc_base  = (state == S_IDLE) ? '0 : acc;
    sum       = {1'b0, acc_base} + {1'b0, r_norm};
    acc_next  = (sum >= MOD_W) ? RW'(sum - MOD_W) : sum[RW-1:0];
    // cnt holds beats already taken, so this beat is the last one when
    // cnt == N_CHUNKS-1 (covers N_CHUNKS==1 from IDLE as well).
    last_beat = (cnt == LAST_CNT);
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = last_beat ? S_DONE : S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_beat) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Accumulator, beat counter, result register and sticky range flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      out_residue <= '0;
      err_range   <= 1'b0;
    end else if (flush) begin
      acc       <= '0;
      cnt       <= '0;
      err_range <= 1'b0;
    end else if (accept) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
      if (in_over)   err_range   <= 1'b1;
      if (last_beat) out_residue <= acc_next;
    end else if (release_out) begin
      acc <= '0;
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mod461_residue_accumulator.sv
// Bench for mod461_residue_accumulator: a 4-beat instance for directed
// cases and a 50-beat instance for randomised frames with stalls.
module tb_mod461_residue_accumulator;

  localparam int RW     = 9;
  localparam int MOD    = 461;
  localparam int NA     = 4;
  localparam int NB     = 50;
  localparam int FRAMES = 250;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic          a_busy, a_err_range;
  logic [RW-1:0] a_in_residue, a_out_residue;
  logic [1:0]    a_dbg_state;

  logic          b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic          b_busy, b_err_range;
  logic [RW-1:0] b_in_residue, b_out_residue;
  logic [1:0]    b_dbg_state;

  mod461_residue_accumulator #(.MODULUS(MOD), .RW(RW), .N_CHUNKS(NA)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_residue(a_in_residue),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_residue(a_out_residue),
    .busy(a_busy), .err_range(a_err_range), .dbg_state(a_dbg_state)
  );

  mod461_residue_accumulator #(.MODULUS(MOD), .RW(RW), .N_CHUNKS(NB)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_residue(b_in_residue),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_residue(b_out_residue),
    .busy(b_busy), .err_range(b_err_range), .dbg_state(b_dbg_state)
  );

  // scoreboard
  logic [RW-1:0] exp_a_q[$];
  logic [RW-1:0] exp_b_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int a_sum = 0, a_cnt = 0, b_sum = 0, b_cnt = 0;
  int b_got = 0;
  logic b_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output monitors: every completed output handshake pops one expected result.
  always @(negedge clk) begin
    if (a_rst_n && a_out_valid && a_out_ready && !a_flush) begin
      if (exp_a_q.size() == 0) check("a_unexpected_out", exp_a_q.size(), 1);
      else                     check("a_result", a_out_residue, exp_a_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_out_valid && b_out_ready && !b_flush) begin
      b_got++;
      if (exp_b_q.size() == 0) check("b_unexpected_out", exp_b_q.size(), 1);
      else                     check("b_result", b_out_residue, exp_b_q.pop_front());
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic a_send(input logic [RW-1:0] v);
    int t = 0;
    a_in_residue = v;
    a_in_valid   = 1'b1;
    @(negedge clk);
    while (!a_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("a_in_ready_timeout", t, 0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_sum += int'(v);
    a_cnt++;
    if (a_cnt == NA) begin
      exp_a_q.push_back(RW'(a_sum % MOD));
      a_sum = 0;
      a_cnt = 0;
    end
  endtask

  task automatic a_frame(input int v0, input int v1, input int v2, input int v3);
    a_send(RW'(v0));
    a_send(RW'(v1));
    a_send(RW'(v2));
    a_send(RW'(v3));
  endtask

  task automatic a_drain();
    int t = 0;
    while (exp_a_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("a_drain_timeout", exp_a_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic b_send(input logic [RW-1:0] v);
    int t = 0;
    b_in_residue = v;
    b_in_valid   = 1'b1;
    @(negedge clk);
    while (!b_in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("b_in_ready_timeout", t, 0);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_sum += int'(v);
    b_cnt++;
    if (b_cnt == NB) begin
      exp_b_q.push_back(RW'(b_sum % MOD));
      b_sum = 0;
      b_cnt = 0;
    end
  endtask

  // random output back-pressure for the 50-beat instance
  initial begin
    b_out_ready = 1'b0;
    @(posedge b_rst_n);
    while (!b_done) begin
      @(posedge clk); #1;
      b_out_ready = ($urandom_range(0, 1) != 0);
    end
    b_out_ready = 1'b1;
  end

  // main sequence
  initial begin
    a_rst_n = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_in_residue = '0; a_out_ready = 1'b1;
    b_rst_n = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_residue = '0;
    #12;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_residue", a_out_residue, 0);
    check("rst_busy", a_busy, 0);
    check("rst_err_range", a_err_range, 0);
    check("rst_state", a_dbg_state, 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", a_in_ready, 1);

    // all-maximum beats: 4*460 mod 461 = 457, one-cycle out_valid
    a_frame(460, 460, 460, 460);
    check("t1_out_valid", a_out_valid, 1);
    check("t1_in_ready_done", a_in_ready, 0);
    check("t1_busy", a_busy, 1);
    check("t1_err_range", a_err_range, 0);
    @(posedge clk); #1;
    check("t1_out_valid_drop", a_out_valid, 0);
    a_drain();

    // small values and the sum == modulus boundary
    a_frame(0, 0, 0, 1);
    a_drain();
    a_frame(230, 231, 0, 0);
    a_drain();
    check("t2_boundary_value", a_out_residue, 0);

    // out-of-range input sets sticky err_range
    a_frame(500, 10, 0, 0);
    check("t3_err_set", a_err_range, 1);
    check("t3_value", a_out_residue, 49);
    a_drain();
    a_frame(1, 2, 3, 4);
    a_drain();
    check("t3_err_sticky", a_err_range, 1);

    // held result under back-pressure
    a_out_ready = 1'b0;
    a_frame(100, 200, 300, 400);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", a_out_valid, 1);
      check("t4_hold_value", a_out_residue, 78);
      check("t4_hold_in_ready", a_in_ready, 0);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_released", a_out_valid, 0);
    check("t4_value_held", a_out_residue, 78);
    check("t4_in_ready", a_in_ready, 1);
    check("t4_queue_empty", exp_a_q.size(), 0);

    // flush after two beats, with a beat offered in the flush cycle
    a_send(RW'(7));
    a_send(RW'(9));
    a_in_valid = 1'b1; a_in_residue = RW'(100); a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0; a_in_valid = 1'b0;
    a_sum = 0; a_cnt = 0;
    check("t5_flush_state", a_dbg_state, 0);
    check("t5_flush_busy", a_busy, 0);
    check("t5_flush_err", a_err_range, 0);
    a_frame(5, 6, 7, 8);
    a_drain();
    check("t5_after_flush", a_out_residue, 26);

    // asynchronous reset mid-frame
    a_send(RW'(300));
    a_send(RW'(300));
    a_rst_n = 1'b0;
    #1;
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_out_valid", a_out_valid, 0);
    check("t5_rst_out_residue", a_out_residue, 0);
    check("t5_rst_state", a_dbg_state, 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    a_sum = 0; a_cnt = 0;
    @(posedge clk); #1;
    a_frame(1, 1, 1, 1);
    a_drain();
    check("t5_after_rst", a_out_residue, 4);

    // random 50-beat frames with input gaps and output stalls
    for (int f = 0; f < FRAMES; f++) begin
      for (int i = 0; i < NB; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        b_send(RW'($urandom_range(0, 511)));
      end
    end
    b_done = 1'b1;
    begin
      int t = 0;
      while (exp_b_q.size() != 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) check("b_drain_timeout", exp_b_q.size(), 0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("b_frame_count", b_got, FRAMES);
    check("a_leftover", exp_a_q.size(), 0);
    check("b_idle_at_end", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
